// File: rtl/pe_accumulator_pkg.sv
// Shared PE package: default datapath widths and the accumulator FSM encoding.
package pe_accumulator_pkg;

    localparam int IN_W_DEF  = 15;
    localparam int ACC_W_DEF = 24;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_t;

endpackage

// File: rtl/pe_accumulator_sat_add.sv
// Combinational signed adder that clamps to the representable range on overflow.
module sat_add #(
    parameter int W = 24
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                ovf
);

    logic signed [W-1:0] raw;
    logic signed [W-1:0] max_val;
    logic signed [W-1:0] min_val;

    assign raw     = a + b;
    assign max_val = {1'b0, {(W-1){1'b1}}};
    assign min_val = {1'b1, {(W-1){1'b0}}};

    // Overflow only when both operands share a sign the raw result lacks.
    assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
    assign sum = ovf ? (a[W-1] ? min_val : max_val) : raw;

endmodule

// File: rtl/pe_accumulator.sv
// Group accumulator behind the PE stage: sums signed partial products per first..last group
// with saturation, and presents one registered result per group on a valid/ready port.
module pe_accumulator
    import pe_accumulator_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic signed [IN_W-1:0]  i_prod,
    input  logic                    i_first,
    input  logic                    i_last,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic signed [ACC_W-1:0] o_sum,
    output logic [CNT_W-1:0]        o_count,
    output logic                    o_sat,
    output logic                    o_err
);

    localparam int EXT_W = ACC_W - IN_W;

    acc_state_t state, state_nxt;

    logic signed [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0]        count, count_nxt;
    logic                    sat, sat_nxt;

    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] add_sum;
    logic                    add_ovf;
    logic [CNT_W-1:0]        count_inc;

    logic accept, start, cont, err, close, drain;

    assign o_ready  = ~o_valid | i_ready;
    assign accept   = i_valid & o_ready;
    assign prod_ext = {{EXT_W{i_prod[IN_W-1]}}, i_prod};

    // An opening beat restarts the group from any state; a continuation needs an open group.
    assign start = accept & i_first;
    assign cont  = accept & ~i_first & (state == ACCUM);
    assign err   = accept & ~i_first & (state != ACCUM);
    assign close = (start | cont) & i_last;
    assign drain = o_valid & i_ready;

    assign count_inc = (count == {CNT_W{1'b1}}) ? count : count + 1'b1;

    sat_add #(.W(ACC_W)) u_sat_add (
        .a   (acc),
        .b   (prod_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_comb begin
        acc_nxt   = acc;
        count_nxt = count;
        sat_nxt   = sat;
        if (start) begin
            acc_nxt   = prod_ext;
            count_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
            sat_nxt   = 1'b0;
        end else if (cont) begin
            acc_nxt   = add_sum;
            count_nxt = count_inc;
            sat_nxt   = sat | add_ovf;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = i_last ? HOLD : ACCUM;
            end
            ACCUM: begin
                if (close)      state_nxt = HOLD;
                else if (start) state_nxt = ACCUM;
            end
            HOLD: begin
                // A dropped non-first beat while draining still consumes the result.
                if (close)      state_nxt = HOLD;
                else if (start) state_nxt = ACCUM;
                else if (drain) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc     <= '0;
            count   <= '0;
            sat     <= 1'b0;
            o_sum   <= '0;
            o_count <= '0;
            o_sat   <= 1'b0;
            o_valid <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            acc   <= acc_nxt;
            count <= count_nxt;
            sat   <= sat_nxt;
            o_err <= err;
            if (close) begin
                o_sum   <= acc_nxt;
                o_count <= count_nxt;
                o_sat   <= sat_nxt;
                o_valid <= 1'b1;
            end else if (drain) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pe_accumulator.sv
// Directed bench for pe_accumulator: group sums, stall, saturation, error pulse, reset, throughput.
module tb_pe_accumulator;

    logic               i_clk;
    logic               i_rst_n;
    logic               i_valid;
    logic               o_ready;
    logic signed [14:0] i_prod;
    logic               i_first;
    logic               i_last;
    logic               o_valid;
    logic               i_ready;
    logic signed [23:0] o_sum;
    logic [7:0]         o_count;
    logic               o_sat;
    logic               o_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    pe_accumulator dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_prod  (i_prod),
        .i_first (i_first),
        .i_last  (i_last),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_sum   (o_sum),
        .o_count (o_count),
        .o_sat   (o_sat),
        .o_err   (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input int p, input logic f, input logic l);
        i_valid = v;
        i_prod  = 15'(p);
        i_first = f;
        i_last  = l;
    endtask

    task automatic flush();
        drive(0, 0, 0, 0);
        i_ready = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        #3;
        total_cnt++;
        if ({o_valid, o_sum, o_count, o_sat, o_err} !== 35'd0)
            $display("FAIL reset_outputs: got v=%b sum=%0d cnt=%0d sat=%b err=%b, want all 0",
                     o_valid, o_sum, o_count, o_sat, o_err);
        else pass_cnt++;
        total_cnt++;
        if (o_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", o_ready);
        else pass_cnt++;
        step();
        i_rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_group();
        i_ready = 1'b1;
        drive(1, 100, 1, 0); step();
        total_cnt++;
        if (o_valid !== 1'b0) $display("FAIL basic_midgroup_valid: got %b want 0", o_valid);
        else pass_cnt++;
        drive(1, -30, 0, 0); step();
        drive(1, 64, 0, 1);  step();
        total_cnt++;
        if (o_valid !== 1'b1 || o_sum !== 134 || o_count !== 8'd3 || o_sat !== 1'b0)
            $display("FAIL basic_result: got v=%b sum=%0d cnt=%0d sat=%b want 1/134/3/0",
                     o_valid, o_sum, o_count, o_sat);
        else pass_cnt++;
        drive(0, 0, 0, 0); step();
        total_cnt++;
        if (o_valid !== 1'b0 || o_sum !== 134)
            $display("FAIL basic_drain: got v=%b sum=%0d want 0/134", o_valid, o_sum);
        else pass_cnt++;
    endtask

    task automatic test_hold();
        i_ready = 1'b0;
        drive(1, -16384, 1, 1); step();
        drive(1, 5, 1, 1);
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (o_valid !== 1'b1 || o_sum !== -16384 || o_count !== 8'd1 || o_ready !== 1'b0)
                $display("FAIL hold_cycle%0d: got v=%b sum=%0d cnt=%0d rdy=%b want 1/-16384/1/0",
                         i, o_valid, o_sum, o_count, o_ready);
            else pass_cnt++;
            step();
        end
        i_ready = 1'b1;
        #1;
        total_cnt++;
        if (o_ready !== 1'b1) $display("FAIL hold_release_ready: got %b want 1", o_ready);
        else pass_cnt++;
        step();
        total_cnt++;
        if (o_valid !== 1'b1 || o_sum !== 5 || o_count !== 8'd1)
            $display("FAIL hold_stalled_beat: got v=%b sum=%0d cnt=%0d want 1/5/1",
                     o_valid, o_sum, o_count);
        else pass_cnt++;
        flush();
    endtask

    task automatic test_saturation();
        i_ready = 1'b1;
        // 504 + 512*16383 = 8388600, then +16383 overflows.
        drive(1, 504, 1, 0); step();
        for (int i = 0; i < 512; i++) begin
            drive(1, 16383, 0, 0); step();
        end
        drive(1, 16383, 0, 1); step();
        total_cnt++;
        if (o_valid !== 1'b1 || o_sum !== 8388607 || o_sat !== 1'b1 || o_count !== 8'd255)
            $display("FAIL sat_pos: got v=%b sum=%0d sat=%b cnt=%0d want 1/8388607/1/255",
                     o_valid, o_sum, o_sat, o_count);
        else pass_cnt++;
        drive(1, 1, 1, 1); step();
        total_cnt++;
        if (o_valid !== 1'b1 || o_sum !== 1 || o_sat !== 1'b0 || o_count !== 8'd1)
            $display("FAIL sat_cleared: got v=%b sum=%0d sat=%b cnt=%0d want 1/1/0/1",
                     o_valid, o_sum, o_sat, o_count);
        else pass_cnt++;
        // 512 * -16384 lands exactly on the minimum; one more -1 clamps.
        drive(1, -16384, 1, 0); step();
        for (int i = 0; i < 511; i++) begin
            drive(1, -16384, 0, 0); step();
        end
        drive(1, -1, 0, 1); step();
        total_cnt++;
        if (o_sum !== -8388608 || o_sat !== 1'b1 || o_count !== 8'd255)
            $display("FAIL sat_neg: got sum=%0d sat=%b cnt=%0d want -8388608/1/255",
                     o_sum, o_sat, o_count);
        else pass_cnt++;
        drive(1, -16384, 1, 0); step();
        for (int i = 0; i < 511; i++) begin
            drive(1, -16384, 0, 0); step();
        end
        drive(1, 0, 0, 1); step();
        total_cnt++;
        if (o_sum !== -8388608 || o_sat !== 1'b0)
            $display("FAIL sat_neg_exact: got sum=%0d sat=%b want -8388608/0", o_sum, o_sat);
        else pass_cnt++;
        flush();
    endtask

    task automatic test_err();
        i_ready = 1'b1;
        drive(1, 9, 0, 1); step();
        total_cnt++;
        if (o_err !== 1'b1 || o_valid !== 1'b0)
            $display("FAIL err_pulse: got err=%b v=%b want 1/0", o_err, o_valid);
        else pass_cnt++;
        drive(0, 0, 0, 0); step();
        total_cnt++;
        if (o_err !== 1'b0 || o_valid !== 1'b0)
            $display("FAIL err_one_cycle: got err=%b v=%b want 0/0", o_err, o_valid);
        else pass_cnt++;
        drive(1, 5, 1, 0); step();
        drive(1, 7, 1, 1); step();
        total_cnt++;
        if (o_valid !== 1'b1 || o_sum !== 7 || o_count !== 8'd1 || o_err !== 1'b0)
            $display("FAIL err_restart: got v=%b sum=%0d cnt=%0d err=%b want 1/7/1/0",
                     o_valid, o_sum, o_count, o_err);
        else pass_cnt++;
        flush();
    endtask

    task automatic test_reset_midgroup();
        i_ready = 1'b1;
        drive(1, 10, 1, 0); step();
        drive(1, 20, 0, 0); step();
        drive(0, 0, 0, 0);
        i_rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({o_valid, o_sum, o_count, o_sat, o_err} !== 35'd0)
            $display("FAIL rst_mid_outputs: got v=%b sum=%0d cnt=%0d sat=%b err=%b want all 0",
                     o_valid, o_sum, o_count, o_sat, o_err);
        else pass_cnt++;
        step();
        i_rst_n = 1'b1;
        drive(1, 99, 0, 1); step();
        total_cnt++;
        if (o_err !== 1'b1 || o_valid !== 1'b0)
            $display("FAIL rst_mid_needs_first: got err=%b v=%b want 1/0", o_err, o_valid);
        else pass_cnt++;
        drive(1, 3, 1, 1); step();
        total_cnt++;
        if (o_valid !== 1'b1 || o_sum !== 3 || o_count !== 8'd1)
            $display("FAIL rst_mid_next: got v=%b sum=%0d cnt=%0d want 1/3/1",
                     o_valid, o_sum, o_count);
        else pass_cnt++;
        flush();
    endtask

    task automatic test_back_to_back();
        i_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(1, i, 1, 1); step();
            total_cnt++;
            if (o_valid !== 1'b1 || o_sum !== i || o_count !== 8'd1)
                $display("FAIL b2b_beat%0d: got v=%b sum=%0d cnt=%0d want 1/%0d/1",
                         i, o_valid, o_sum, o_count, i);
            else pass_cnt++;
        end
        drive(0, 0, 0, 0); step();
        total_cnt++;
        if (o_valid !== 1'b0 || o_sum !== 3)
            $display("FAIL b2b_drain: got v=%b sum=%0d want 0/3", o_valid, o_sum);
        else pass_cnt++;
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_ready = 1'b1;
        drive(0, 0, 0, 0);
        test_reset();
        test_basic_group();
        test_hold();
        test_saturation();
        test_err();
        test_reset_midgroup();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
